ripple_count_extender: RTL and testbench
========================================

// Module: ripple_count_extender
// PURPOSE
// - Downstream consumer of the 2-bit ripple counter outputs (q0, q1).
// - Resynchronises them into the system clock domain and rejects ripple glitches
//   (e.g. 01->00->10).
// - Extends the 2-bit code into a wide monotonic count and flags skipped codes.
// - Delivers count snapshots to logic over a valid/ready handshake.
// PARAMETERS
// - EXT_W         16  width of upper (wrap) counter; count width = EXT_W+2
// - SYNC_STAGES   2   synchroniser flops per input bit (>=2)
// - STABLE_CYCLES 2   consecutive equal synced samples required to accept a code (>=1)
// PORTS
// - clk          in   1        system clock, rising edge
// - reset        in   1        asynchronous, active-high; clears all state
// - q0           in   1        ripple counter bit 0 (asynchronous to clk)
// - q1           in   1        ripple counter bit 1 (asynchronous to clk)
// - clear        in   1        synchronous clear of extended count and flags
// - count        out  EXT_W+2  snapshot {upper, code}
// - count_valid  out  1        snapshot valid
// - count_ready  in   1        consumer accepts snapshot
// - overflow     out  1        sticky: upper wrapped past all-ones
// - step_err     out  1        sticky: accepted code advanced by 2 or 3
// BEHAVIOUR
// - Reset: count=0, count_valid=0, overflow=0, step_err=0. Accepted code=00, upper=0,
//   filter empty. Ripple counter shares reset, so 00 is the baseline.
// - Sync: {q1,q0} passes through SYNC_STAGES flops. No other logic touches raw inputs.
// - Filter: tracks candidate code and equal-sample run length.
//   - A synced value differing from the candidate restarts the run at 1.
//   - A code is accepted on the cycle its run reaches STABLE_CYCLES and it differs
//     from the accepted code.
// - Delta d = (new - accepted) mod 4. The counter only counts up, so d=3 is not backward.
//   - d=1: normal advance.
//   - d=2,3: advance by d and set step_err.
// - Upper increments when new code < accepted code (wrap 11->00 or any modular wrap).
//   - Upper at all-ones incrementing wraps to 0 and sets overflow.
// - Live count = {upper, accepted code}, updated on the acceptance edge.
// - Output stage (evaluated when !count_valid or count_ready):
//   - If live != last_sent: count <= live, last_sent <= live, count_valid <= 1.
//   - Otherwise: count_valid <= 0.
// - Handshake rules:
//   - While count_valid && !count_ready, count is held stable.
//   - Intermediate live values during a stall are coalesced; the latest is sent next.
// - Latency: q stable before edge k -> count_valid high after edge
//   k + SYNC_STAGES + STABLE_CYCLES (5 cycles at defaults), given output idle.
// - clear (sync):
//   - upper<=0, overflow<=0, step_err<=0, count_valid<=0, count<=0, last_sent<={0,code}.
//   - Accepted code is kept.
//   - clear beats a same-cycle wrap increment and same-cycle flag sets.
//   - A same-cycle code acceptance still updates the code.
// - Reset mid-operation: all state clears immediately; a pending snapshot is dropped.
// - count_ready with count_valid low: no effect.
// STRUCTURE
// - Package ripple_pkg: localparam CODE_W=2; typedef logic [1:0] code_t;
//   function code_delta(new, old) returning 2-bit modular difference.
// - Sub-module ripple_sync_filter (SYNC_STAGES, STABLE_CYCLES):
//   - Inputs: clk, reset, q0, q1.
//   - Outputs: code_t code, 1-cycle pulse code_accept.
// - Top holds delta/upper/flag logic and the output register slice.
// TESTING
// - Reset, q held 00 for 20 cycles -> count_valid never asserts, count=0, flags 0.
// - Step 00->01, count_ready=1 -> count_valid pulses 1 cycle, count=1, exactly
//   5 cycles after q change.
// - Glitch 01->00 for 1 cycle then 10 (STABLE_CYCLES=2):
//   - count goes 1->2.
//   - 00 never accepted.
//   - step_err stays 0.
// - 8 clean counts with count_ready=1 -> count sequence 1..8, upper=2 at end.
//   EXT_W=2 run of 16 counts -> count wraps to 0, overflow=1.
// - Jump 00->10 (held stable) -> count=2, step_err=1; then clear -> count_valid=0,
//   step_err=0, upper=0.
// - count_ready=0 across 3 advances -> count holds first snapshot (1);
//   raise count_ready -> next snapshot is 3, no 2.

Source files
------------

// File: rtl/ripple_pkg.sv
// Shared types for the ripple counter extender: 2-bit code type and modular step helper.
package ripple_pkg;

  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;

  // Forward distance from old_code to new_code; the ripple counter never counts down.
  function automatic code_t code_delta(code_t new_code, code_t old_code);
    return code_t'(new_code - old_code);
  endfunction

endpackage

// File: rtl/ripple_count_extender_if.sv
// Snapshot handshake between the count extender (master) and its consumer (slave).
interface ripple_count_extender_if #(
  parameter int COUNT_W = 18
) ();

  logic [COUNT_W-1:0] count;
  logic               count_valid;
  logic               count_ready;

  modport master (output count, output count_valid, input count_ready);
  modport slave  (input count, input count_valid, output count_ready);

endinterface

// File: rtl/ripple_sync_filter.sv
// Resynchronises the raw ripple bits and accepts a code only after it has been seen
// STABLE_CYCLES times in a row, so transient ripple states never reach the counter.
module ripple_sync_filter
  import ripple_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  q0,
  input  logic  q1,
  output code_t code,
  output code_t new_code,
  output logic  code_accept
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  code_t            sync_q [SYNC_STAGES];
  code_t            candidate;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;

  // NOTE: the synchroniser chain is a handful of flops, not a RAM, so it is reset
  // like any other state; that keeps the 00 baseline consistent with the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {q1, q0};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign new_code = sync_q[SYNC_STAGES-1];

  // NOTE: run_next gets a default before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    run_next = run;
    if (new_code != candidate)
      run_next = RUN_W'(1);
    else if (run < RUN_W'(STABLE_CYCLES))
      run_next = run + RUN_W'(1);
  end

  // Combinational pulse so the extender updates on the same edge the code is taken.
  assign code_accept = (run_next == RUN_W'(STABLE_CYCLES)) && (new_code != code);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      run       <= '0;
      code      <= '0;
    end else begin
      candidate <= new_code;
      run       <= run_next;
      if (code_accept) code <= new_code;
    end
  end

endmodule

// File: rtl/ripple_count_extender.sv
// Extends the filtered 2-bit ripple code into a wide count with sticky overflow and
// skipped-code flags, and hands snapshots out through a coalescing register slice.
module ripple_count_extender
  import ripple_pkg::*;
#(
  parameter int EXT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     q0,
  input  logic                     q1,
  input  logic                     clear,
  ripple_count_extender_if.master  bus,
  output logic                     overflow,
  output logic                     step_err
);

  localparam int COUNT_W = EXT_W + CODE_W;

  code_t              code;
  code_t              new_code;
  code_t              code_next;
  logic               code_accept;
  logic               wrap;
  logic               big_step;
  logic [EXT_W-1:0]   upper;
  logic [COUNT_W-1:0] live;
  logic [COUNT_W-1:0] last_sent;

  ripple_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .q0         (q0),
    .q1         (q1),
    .code       (code),
    .new_code   (new_code),
    .code_accept(code_accept)
  );

  // A smaller new code can only mean the 2-bit counter passed 11 on its way here.
  assign wrap      = code_accept && (new_code < code);
  assign big_step  = code_accept && (code_delta(new_code, code) >= code_t'(2));
  assign code_next = code_accept ? new_code : code;
  assign live      = {upper, code};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upper    <= '0;
      overflow <= 1'b0;
      step_err <= 1'b0;
    end else if (clear) begin
      upper    <= '0;
      overflow <= 1'b0;
      step_err <= 1'b0;
    end else begin
      if (wrap) begin
        upper <= upper + EXT_W'(1);
        if (&upper) overflow <= 1'b1;
      end
      if (big_step) step_err <= 1'b1;
    end
  end

  // Output slice: while stalled, live keeps moving and only the latest value is sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.count       <= '0;
      bus.count_valid <= 1'b0;
      last_sent       <= '0;
    end else if (clear) begin
      bus.count       <= '0;
      bus.count_valid <= 1'b0;
      last_sent       <= {EXT_W'(0), code_next};
    end else if (!bus.count_valid || bus.count_ready) begin
      if (live != last_sent) begin
        bus.count       <= live;
        last_sent       <= live;
        bus.count_valid <= 1'b1;
      end else begin
        bus.count_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_extender.sv
// Scoreboarded bench: stimulus pushes expected snapshots from a plain-arithmetic
// running-total model; a negedge monitor pops and compares every handshake.
module tb_ripple_count_extender;
  import ripple_pkg::*;

  localparam int EXT_W   = 16;
  localparam int CW      = EXT_W + 2;
  localparam int STABLE  = 2;

  logic clk = 1'b0;
  logic reset;
  logic q0, q1, clear;
  logic overflow, step_err, overflow_s, step_err_s;

  ripple_count_extender_if #(.COUNT_W(CW)) bus ();
  ripple_count_extender_if #(.COUNT_W(4))  bus_s ();

  ripple_count_extender #(.EXT_W(EXT_W), .SYNC_STAGES(2), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .clear(clear),
    .bus(bus), .overflow(overflow), .step_err(step_err)
  );

  ripple_count_extender #(.EXT_W(2), .SYNC_STAGES(2), .STABLE_CYCLES(STABLE)) dut_s (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .clear(clear),
    .bus(bus_s), .overflow(overflow_s), .step_err(step_err_s)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     rx_count = 0;
  longint last_rx  = 0;
  bit     coalesce = 1'b0;
  longint sb_q[$];

  // Reference model: unbounded running total of ripple counts since reset/clear.
  longint model_total;
  int     model_code;
  bit     model_step;
  int     prev_q;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(int c);
    int d;
    d = (c - model_code + 4) % 4;
    model_total += d;
    if (d >= 2) model_step = 1'b1;
    model_code = c;
    sb_q.push_back(model_total % (longint'(1) << CW));
  endtask

  // Holds shorter than STABLE samples never survive the filter.
  task automatic drive(int c, int hold);
    {q1, q0} = 2'(c);
    prev_q = c;
    if (hold >= STABLE && c != model_code) model_accept(c);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    {q1, q0} = 2'b00;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_total = 0; model_code = 0; model_step = 1'b0; prev_q = 0;
    sb_q.delete();
  endtask

  // Monitor: one comparison per completed transfer.
  always @(negedge clk) begin
    if (!reset && bus.count_valid && bus.count_ready) begin
      longint act;
      act = longint'(bus.count);
      rx_count++;
      last_rx = act;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got %0d, expected no transfer (t=%0t)", act, $time);
      end else begin
        if (coalesce)
          while (sb_q.size() > 1 && sb_q[0] != act) void'(sb_q.pop_front());
        check("sb_count", act, sb_q[0]);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int lat;
    int rx0;
    bit seen;
    reset = 1'b1; clear = 1'b0; {q1, q0} = 2'b00;
    bus.count_ready = 1'b1;
    bus_s.count_ready = 1'b1;

    // Idle after reset: nothing to send.
    do_reset();
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.count_valid) seen = 1'b1;
    end
    check("idle_valid", seen, 0);
    check("idle_count", bus.count, 0);
    check("idle_overflow", overflow, 0);
    check("idle_step_err", step_err, 0);

    // First step and its latency.
    {q1, q0} = 2'b01; prev_q = 1; model_accept(1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.count_valid && lat < 20);
    check("latency", lat, 5);
    check("first_count", bus.count, 1);
    @(posedge clk); #1;
    check("valid_pulse", bus.count_valid, 0);
    repeat (4) @(posedge clk);
    #1;

    // Ripple glitch 01->00->10.
    rx0 = rx_count;
    drive(0, 1);
    drive(2, 8);
    check("glitch_count", bus.count, 2);
    check("glitch_transfers", rx_count - rx0, 1);
    check("glitch_step_err", step_err, 0);

    // Sixteen clean counts; the narrow instance wraps.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(i % 4, 7);
      if (i == 8) begin
        check("count8", bus.count, 8);
        check("upper8", bus.count >> 2, 2);
      end
    end
    check("count16", bus.count, 16);
    check("wide_overflow", overflow, 0);
    check("narrow_count", bus_s.count, (model_total % 16));
    check("narrow_overflow", overflow_s, (model_total >= 16));

    // Skipped code, then clear.
    do_reset();
    drive(2, 8);
    check("jump_count", bus.count, 2);
    check("jump_step_err", step_err, model_step);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_total = model_code; model_step = 1'b0;
    sb_q.delete();
    check("clear_valid", bus.count_valid, 0);
    check("clear_count", bus.count, 0);
    check("clear_step_err", step_err, 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.count_valid) seen = 1'b1;
    end
    check("clear_quiet", seen, 0);
    drive(3, 8);
    check("post_clear_count", bus.count, model_total);

    // Stall across three advances: intermediate value is coalesced away.
    do_reset();
    coalesce = 1'b1;
    bus.count_ready = 1'b0;
    drive(1, 7);
    drive(2, 7);
    drive(3, 7);
    check("stall_hold_count", bus.count, 1);
    check("stall_hold_valid", bus.count_valid, 1);
    bus.count_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_next_count", bus.count, 3);
    repeat (4) @(posedge clk);
    #1;

    // Randomised codes, glitch lengths and backpressure.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int c;
      int hold;
      if ($urandom_range(0, 3) != 0) c = (prev_q + 1) % 4;
      else c = (prev_q + $urandom_range(1, 3)) % 4;
      hold = (i == 199) ? 8 : $urandom_range(1, 7);
      bus.count_ready = ($urandom_range(0, 4) != 0);
      drive(c, hold);
    end
    bus.count_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_drained", sb_q.size(), 0);
    check("rand_last", last_rx, model_total % (longint'(1) << CW));
    check("rand_step_err", step_err, model_step);
    check("rand_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
